// File: rtl/elastic_pipe_reg.sv
// Elastic STAGES-deep valid/ready register chain; bubbles compress under backpressure.
// Optional PIPE_OCC_EN adds a registered occupancy count output (occ).
module elastic_pipe_reg #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
`ifdef PIPE_OCC_EN
   output logic [$clog2(STAGES+1)-1:0]  occ,
`endif
   input  logic                         out_ready
);

   logic [WIDTH-1:0]  data_q    [STAGES];
   logic [WIDTH-1:0]  prev_data [STAGES];
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] prev_vld;
   logic [STAGES-1:0] take;
   logic              in_xfer;

   // A stage can take a new word unless it and every stage after it are full
   // while the output is stalled. Computed as a flat suffix scan to avoid a
   // bit-to-bit combinational chain inside one vector.
   always_comb begin
      take = '0;
      for (int i = 0; i < STAGES; i++) begin
         take[i] = out_ready;
         for (int j = i; j < STAGES; j++) begin
            if (!vld_q[j]) take[i] = 1'b1;
         end
      end
   end

   assign in_ready  = take[0] && !flush;
   assign in_xfer   = in_valid && in_ready;
   assign out_valid = vld_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

   always_comb begin
      prev_vld     = '0;
      prev_vld[0]  = in_xfer;
      prev_data[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
         prev_vld[i]  = vld_q[i-1];
         prev_data[i] = data_q[i-1];
      end
   end

   // Data registers only load on a valid incoming word so bubbles leave the
   // last word visible on out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      end else if (flush) begin
         vld_q <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (take[i]) begin
               vld_q[i] <= prev_vld[i];
               if (prev_vld[i]) data_q[i] <= prev_data[i];
            end
         end
      end
   end

`ifdef PIPE_OCC_EN
   localparam int OCC_W = $clog2(STAGES+1);

   logic             out_xfer;
   logic [OCC_W-1:0] occ_q;

   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) occ_q <= '0;
      else              occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: default (16x4) and 8x1 instances checked against a
// word/position queue model; occ is checked when PIPE_OCC_EN is defined.
module tb_elastic_pipe_reg;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] in_data;

   logic        a_in_ready, a_out_valid;
   logic [15:0] a_out_data;
   logic        b_in_ready, b_out_valid;
   logic [7:0]  b_out_data;
`ifdef PIPE_OCC_EN
   logic [2:0]  a_occ;
   logic [0:0]  b_occ;
`endif

   always #5 clk = ~clk;

   elastic_pipe_reg #(.WIDTH(16), .STAGES(4)) u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid),
`ifdef PIPE_OCC_EN
      .occ(a_occ),
`endif
      .out_ready(out_ready)
   );

   elastic_pipe_reg #(.WIDTH(8), .STAGES(1)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid),
`ifdef PIPE_OCC_EN
      .occ(b_occ),
`endif
      .out_ready(out_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic sel = 1'b0;

   logic        obs_in_ready, obs_out_valid;
   logic [15:0] obs_out_data;
   int          obs_occ;
   logic [25:0] obs_vec;

   always_comb begin
      if (sel) begin
         obs_in_ready  = b_in_ready;
         obs_out_valid = b_out_valid;
         obs_out_data  = {8'h00, b_out_data};
      end else begin
         obs_in_ready  = a_in_ready;
         obs_out_valid = a_out_valid;
         obs_out_data  = a_out_data;
      end
      obs_occ = 0;
`ifdef PIPE_OCC_EN
      obs_occ = sel ? int'(b_occ) : int'(a_occ);
`endif
      obs_vec = {obs_in_ready, obs_out_valid, obs_out_data, 8'(obs_occ)};
   end

   // Model: queue of words in arrival order, each with its stage position.
   // Each edge, a word advances one position unless the word ahead of it is
   // still occupying the next slot; the head leaves past the last position
   // only when out_ready is high.
   int          S = 4;
   logic [15:0] mask = 16'hFFFF;
   logic [15:0] q_d[$];
   int          q_p[$];
   logic [15:0] last_out = '0;
   logic        m_rst, m_flush, m_iv, m_ordy;
   logic [15:0] m_id;
   logic        exp_in_ready, exp_out_valid;
   logic [15:0] exp_out_data;
   int          exp_occ;
   logic [25:0] exp_vec;

   function automatic int tail_ceiling();
      int ceil;
      ceil = m_ordy ? S : S - 1;
      foreach (q_p[k]) begin
         int np;
         np   = (q_p[k] + 1 < ceil) ? q_p[k] + 1 : ceil;
         ceil = np - 1;
      end
      return ceil;
   endfunction

   function automatic void model_comb();
      exp_out_valid = (q_p.size() > 0) && (q_p[0] == S - 1);
      exp_out_data  = last_out;
      exp_in_ready  = !m_flush && (tail_ceiling() >= 0);
      exp_occ = 0;
`ifdef PIPE_OCC_EN
      exp_occ = q_p.size();
`endif
      exp_vec = {exp_in_ready, exp_out_valid, exp_out_data, 8'(exp_occ)};
   endfunction

   function automatic void model_edge();
      int  ceil;
      logic in_fire;
      if (m_rst) begin
         q_d.delete(); q_p.delete(); last_out = '0;
         return;
      end
      if (m_flush) begin
         q_d.delete(); q_p.delete();
         return;
      end
      in_fire = m_iv && exp_in_ready;
      ceil = m_ordy ? S : S - 1;
      for (int k = 0; k < q_p.size(); k++) begin
         int np;
         np = (q_p[k] + 1 < ceil) ? q_p[k] + 1 : ceil;
         ceil = np - 1;
         q_p[k] = np;
         if (np == S - 1) last_out = q_d[k];
      end
      if (q_p.size() > 0 && q_p[0] == S) begin
         void'(q_p.pop_front());
         void'(q_d.pop_front());
      end
      if (in_fire) begin
         q_d.push_back(m_id & mask);
         q_p.push_back(0);
         if (S == 1) last_out = m_id & mask;
      end
   endfunction

   task automatic drive(input logic r_, input logic f_, input logic iv_,
                        input logic [15:0] d_, input logic or_);
      @(negedge clk);
      rst = r_; flush = f_; in_valid = iv_; in_data = d_; out_ready = or_;
      m_rst = r_; m_flush = f_; m_iv = iv_; m_id = d_; m_ordy = or_;
      #1;
      model_comb();
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 16'h0, 1); tick();
      drive(1, 0, 1, 16'h1234, 1); tick();
      drive(0, 0, 0, 16'h0, 1);
      n_checks++;
      if (obs_vec !== {1'b1, 1'b0, 16'h0000, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_state got {ir,ov,data,occ}=%h exp %h", obs_vec, {1'b1, 1'b0, 16'h0000, 8'd0});
      end
      tick();
   endtask

   task automatic test_stream();
      int first_acc = -1, first_ov = -1, n_out = 0, nxt = 1;
      for (int c = 0; c < 16; c++) begin
         drive(0, 0, nxt <= 8, 16'(nxt), 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL stream c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         if (first_acc < 0 && in_valid && obs_in_ready) first_acc = c;
         if (first_ov < 0 && obs_out_valid) first_ov = c;
         if (obs_out_valid) n_out++;
         if (in_valid && exp_in_ready) nxt++;
         tick();
      end
      n_checks++;
      if (first_ov - first_acc != 4) begin
         n_fail++;
         $display("FAIL stream_latency got %0d exp 4", first_ov - first_acc);
      end
      n_checks++;
      if (n_out != 8) begin
         n_fail++;
         $display("FAIL stream_count got %0d exp 8", n_out);
      end
   endtask

   task automatic test_backpressure();
      int nxt = 0, acc_stall = 0;
      logic [15:0] got[$];
      for (int c = 0; c < 8; c++) begin
         drive(0, 0, nxt < 6, 16'hA000 + 16'(nxt), 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL bp_stall c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         if (in_valid && obs_in_ready) acc_stall++;
         if (in_valid && exp_in_ready) nxt++;
         tick();
      end
      n_checks++;
      if (acc_stall != 4) begin
         n_fail++;
         $display("FAIL bp_accepted got %0d exp 4", acc_stall);
      end
      for (int c = 0; c < 14; c++) begin
         drive(0, 0, nxt < 6, 16'hA000 + 16'(nxt), 1);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL bp_drain c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         if (obs_out_valid) got.push_back(obs_out_data);
         if (in_valid && exp_in_ready) nxt++;
         tick();
      end
      n_checks++;
      if (got.size() != 6) begin
         n_fail++;
         $display("FAIL bp_out_count got %0d exp 6", got.size());
      end
      foreach (got[k]) begin
         n_checks++;
         if (got[k] !== 16'hA000 + 16'(k)) begin
            n_fail++;
            $display("FAIL bp_order idx %0d got %h exp %h", k, got[k], 16'hA000 + 16'(k));
         end
      end
   endtask

   task automatic test_full_throughput();
      int nxt = 0;
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, c < 16, 16'hB000 + 16'(nxt), c >= 6);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL full c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         if (c >= 6 && c < 16) begin
            n_checks++;
            if ({obs_in_ready, obs_out_valid} !== 2'b11) begin
               n_fail++;
               $display("FAIL full_xfer c=%0d got ir/ov=%b exp 11", c, {obs_in_ready, obs_out_valid});
            end
         end
         if (in_valid && exp_in_ready) nxt++;
         tick();
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 3; c++) begin
         drive(0, 0, 1, 16'hC000 + 16'(c), 0);
         tick();
      end
      drive(0, 1, 1, 16'hDEAD, 0);
      n_checks++;
      if (obs_in_ready !== 1'b0 || obs_vec !== exp_vec) begin
         n_fail++;
         $display("FAIL flush_cycle got {ir,ov,data,occ}=%h exp %h", obs_vec, exp_vec);
      end
      tick();
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 0, 16'h0, 1);
         n_checks++;
         if (obs_out_valid !== 1'b0 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL flush_after c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 1, 16'hE000, 1); tick();
      drive(0, 0, 1, 16'hE001, 1); tick();
      drive(1, 0, 1, 16'hE0FF, 1); tick();
      for (int c = 0; c < 6; c++) begin
         drive(0, 0, 0, 16'h0, 1);
         n_checks++;
         if (obs_vec !== {1'b1, 1'b0, 16'h0000, 8'd0} || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid c=%0d got {ir,ov,data,occ}=%h exp %h", c, obs_vec, exp_vec);
         end
         tick();
      end
   endtask

   task automatic test_random(input logic use_b, input int stages, input int ncyc);
      sel  = use_b;
      S    = stages;
      mask = use_b ? 16'h00FF : 16'hFFFF;
      drive(1, 0, 0, 16'h0, 1); tick();
      for (int c = 0; c < ncyc; c++) begin
         drive(0, (stages > 1) && ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
               16'($urandom), $urandom_range(0, 3) != 0);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL random_s%0d c=%0d got {ir,ov,data,occ}=%h exp %h", stages, c, obs_vec, exp_vec);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      m_rst = 1'b1; m_flush = 1'b0; m_iv = 1'b0; m_id = '0; m_ordy = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_full_throughput();
      test_flush();
      test_reset_mid();
      test_random(1'b0, 4, 400);
      test_random(1'b1, 1, 1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
